// File: rtl/mic_level_capture.sv
// Pmod MIC3 (ADCS7476) capture: SPI frame sequencer, 12-bit deserialiser and windowed peak-to-level quantiser.
// Optional macro LEVEL_DECAY_EN: falling level drops one step per window instead of instantly.
module mic_level_capture #(
    parameter int unsigned SCLK_DIV  = 50,
    parameter int unsigned QUIET_CYC = 4,
    parameter int unsigned WINDOW    = 5000,
    parameter int unsigned MIDSCALE  = 2048,
    parameter int unsigned STEP      = 200
) (
    input  logic        basys_clock,
    input  logic        reset_n,
    input  logic        MISO,
    output logic        sclk,
    output logic        clk_samp,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic [3:0]  audio_level,
    output logic        level_valid
);

    localparam int unsigned DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned QH      = 2 * QUIET_CYC;
    localparam int unsigned QH_W    = (QH > 1) ? $clog2(QH) : 1;
    localparam int unsigned WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned SAMP_W  = 12;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned NBITS   = 16;
    localparam int unsigned LVL_W   = 4;
    localparam int unsigned LVL_MAX = 9;

    typedef enum logic [1:0] {
        ST_QUIET = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [QH_W-1:0]    half_cnt_q, half_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SAMP_W-1:0]  shift_q, shift_d;
    logic               sclk_q, sclk_d;
    logic               clk_samp_q, clk_samp_d;
    logic [SAMP_W-1:0]  sample_q, sample_d;
    logic               sample_valid_q, sample_valid_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [SAMP_W-1:0]  peak_q, peak_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               level_valid_q, level_valid_d;

    logic               tick_c;
    logic [SAMP_W-1:0]  amp_c;
    logic [SAMP_W-1:0]  peak_max_c;
    logic [LVL_W-1:0]   new_level_c;

    // Free-running half-period divider; tick_c marks each wrap.
    always_comb begin
        tick_c = (div_q == DIV_W'(SCLK_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    end

    // Frame sequencer. The 12-bit shifter lets the four leading zeros fall off the top.
    always_comb begin
        state_d        = state_q;
        half_cnt_d     = half_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        sclk_d         = sclk_q;
        clk_samp_d     = clk_samp_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;

        case (state_q)
            ST_QUIET: begin
                sclk_d     = 1'b1;
                clk_samp_d = 1'b1;
                if (tick_c) begin
                    if (half_cnt_q == QH_W'(QH - 1)) begin
                        half_cnt_d = '0;
                        bit_cnt_d  = '0;
                        clk_samp_d = 1'b0;
                        state_d    = ST_SHIFT;
                    end else begin
                        half_cnt_d = half_cnt_q + QH_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (tick_c) begin
                    if (bit_cnt_q == BIT_W'(NBITS)) begin
                        sclk_d     = 1'b1;
                        clk_samp_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        sclk_d = ~sclk_q;
                        if (!sclk_q) begin
                            shift_d   = {shift_q[SAMP_W-2:0], MISO};
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                sclk_d         = 1'b1;
                clk_samp_d     = 1'b1;
                sample_d       = shift_q;
                sample_valid_d = 1'b1;
                half_cnt_d     = '0;
                state_d        = ST_QUIET;
            end
            default: begin
                sclk_d     = 1'b1;
                clk_samp_d = 1'b1;
                state_d    = ST_QUIET;
            end
        endcase
    end

    // Positive half-wave amplitude, running peak and 0..9 quantisation.
    always_comb begin
        amp_c       = (sample_q > SAMP_W'(MIDSCALE)) ? sample_q - SAMP_W'(MIDSCALE) : '0;
        peak_max_c  = (amp_c > peak_q) ? amp_c : peak_q;
        new_level_c = '0;
        for (int unsigned k = 1; k <= LVL_MAX; k++) begin
            if (32'(peak_max_c) >= k * STEP) begin
                new_level_c = LVL_W'(k);
            end
        end
    end

    // Window bookkeeping; the closing sample is folded into peak_max_c.
    always_comb begin
        peak_d        = peak_q;
        win_cnt_d     = win_cnt_q;
        level_d       = level_q;
        level_valid_d = 1'b0;

        if (sample_valid_q) begin
            if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                peak_d        = '0;
                win_cnt_d     = '0;
                level_valid_d = 1'b1;
`ifdef LEVEL_DECAY_EN
                if (new_level_c >= level_q) begin
                    level_d = new_level_c;
                end else begin
                    level_d = level_q - LVL_W'(1);
                end
`else
                level_d = new_level_c;
`endif
            end else begin
                peak_d    = peak_max_c;
                win_cnt_d = win_cnt_q + WIN_W'(1);
            end
        end
    end

    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_QUIET;
            div_q          <= '0;
            half_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            sclk_q         <= 1'b1;
            clk_samp_q     <= 1'b1;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            win_cnt_q      <= '0;
            peak_q         <= '0;
            level_q        <= '0;
            level_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            half_cnt_q     <= half_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            sclk_q         <= sclk_d;
            clk_samp_q     <= clk_samp_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            win_cnt_q      <= win_cnt_d;
            peak_q         <= peak_d;
            level_q        <= level_d;
            level_valid_q  <= level_valid_d;
        end
    end

    assign sclk         = sclk_q;
    assign clk_samp     = clk_samp_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign audio_level  = level_q;
    assign level_valid  = level_valid_q;

endmodule

// File: tb/tb_mic_level_capture.sv
// Scoreboard bench for mic_level_capture: ADC model feeds queued words, monitor checks samples and window levels.
module tb_mic_level_capture;

    localparam int unsigned S = 4;
    localparam int unsigned Q = 2;
    localparam int unsigned W = 8;

    logic        basys_clock = 1'b0;
    logic        reset_n     = 1'b0;
    logic        MISO        = 1'b0;
    logic        sclk;
    logic        clk_samp;
    logic [11:0] sample;
    logic        sample_valid;
    logic [3:0]  audio_level;
    logic        level_valid;

    mic_level_capture #(
        .SCLK_DIV (S),
        .QUIET_CYC(Q),
        .WINDOW   (W),
        .MIDSCALE (2048),
        .STEP     (200)
    ) dut (
        .basys_clock (basys_clock),
        .reset_n     (reset_n),
        .MISO        (MISO),
        .sclk        (sclk),
        .clk_samp    (clk_samp),
        .sample      (sample),
        .sample_valid(sample_valid),
        .audio_level (audio_level),
        .level_valid (level_valid)
    );

    always #5 basys_clock = ~basys_clock;

    logic [11:0] exp_s[$];
    logic [3:0]  exp_l[$];
    logic [15:0] adc_q[$];
    int n_vec   = 0;
    int n_miss  = 0;
    int cur_lvl = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    // One window of W samples: fill everywhere except val at pos; nl is the hand-computed raw level.
    task automatic push_win(input int nl, input int pos, input logic [11:0] val,
                            input logic [11:0] fill, input logic [3:0] top);
        logic [11:0] s;
        for (int i = 0; i < int'(W); i++) begin
            s = (i == pos) ? val : fill;
            adc_q.push_back({top, s});
            exp_s.push_back(s);
        end
`ifdef LEVEL_DECAY_EN
        cur_lvl = (nl >= cur_lvl) ? nl : cur_lvl - 1;
`else
        cur_lvl = nl;
`endif
        exp_l.push_back(4'(cur_lvl));
    endtask

    // ADC model: load a word on chip-select fall, present bits MSB-first on sclk falling edges.
    logic [15:0] adc_word = 16'h0;
    int          adc_bit  = 15;
    always @(negedge clk_samp) begin
        if (adc_q.size() > 0) adc_word = adc_q.pop_front();
        else                  adc_word = 16'h0;
        adc_bit = 15;
    end
    always @(negedge sclk) begin
        if (!clk_samp && adc_bit >= 0) begin
            MISO = adc_word[adc_bit];
            adc_bit--;
        end
    end

    always @(negedge basys_clock) begin
        if (reset_n && sample_valid) begin
            if (exp_s.size() == 0) chk("unexpected_sample_valid", 1, 0);
            else                   chk("sample", int'(sample), int'(exp_s.pop_front()));
        end
        if (reset_n && level_valid) begin
            if (exp_l.size() == 0) chk("unexpected_level_valid", 1, 0);
            else                   chk("audio_level", int'(audio_level), int'(exp_l.pop_front()));
        end
    end

    initial begin
        int n, low, rises, r1, r2, sclk_bad, zero_bad;
        logic prev;

        push_win(3, 0, 12'hAAA, 12'h800, 4'h0);
        push_win(0, 5, 12'h000, 12'h7FF, 4'hF);
        push_win(5, 3, 12'hBEF, 12'h800, 4'h0);
        push_win(5, 1, 12'hBE8, 12'h800, 4'h0);
        push_win(5, 7, 12'hBE8, 12'h800, 4'h0);
        push_win(0, 0, 12'h800, 12'h800, 4'h0);
        push_win(9, 4, 12'hFFF, 12'h800, 4'h0);
        push_win(0, 2, 12'h801, 12'h800, 4'h0);
        push_win(0, 6, 12'h7FF, 12'h800, 4'h0);
        push_win(4, 2, 12'hBE7, 12'h800, 4'h0);
        adc_q.push_back(16'h0FFF);

        repeat (10) @(posedge basys_clock);
        #1;
        chk("rst_clk_samp", int'(clk_samp), 1);
        chk("rst_sclk", int'(sclk), 1);
        @(negedge basys_clock);
        reset_n = 1'b1;

        n = 0; sclk_bad = 0; zero_bad = 0;
        do begin
            @(posedge basys_clock); n++; #1;
            if (sclk !== 1'b1) sclk_bad++;
            if (sample != 12'h0 || audio_level != 4'h0 || sample_valid || level_valid) zero_bad++;
        end while (clk_samp && n < 1000);
        chk("quiet_len", n, int'(2 * Q * S));
        chk("quiet_sclk_high", sclk_bad, 0);
        chk("quiet_outputs_zero", zero_bad, 0);

        low = 0; rises = 0; r1 = 0; r2 = 0; prev = sclk;
        do begin
            @(posedge basys_clock); low++; #1;
            if (sclk && !prev) begin
                rises++;
                if (rises == 1) r1 = low;
                if (rises == 2) r2 = low;
            end
            prev = sclk;
        end while (!clk_samp && low < 1000);
        chk("frame_sclk_rises", rises, 16);
        chk("sclk_period", r2 - r1, int'(2 * S));
        chk("cs_low_len", int'(low >= int'(32 * S) && low <= int'(33 * S)), 1);

        n = 0;
        while ((exp_s.size() > 0 || exp_l.size() > 0) && n < 20000) begin
            @(posedge basys_clock); n++;
        end
        chk("drain_timeout", exp_s.size() + exp_l.size(), 0);

        n = 0;
        while (clk_samp && n < 1000) begin
            @(posedge basys_clock); #1; n++;
        end
        chk("abort_frame_start", int'(clk_samp), 0);
        rises = 0; prev = sclk; n = 0;
        while (rises < 7 && n < 1000) begin
            @(posedge basys_clock); #1; n++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        adc_q.push_back(16'h0123);
        exp_s.push_back(12'h123);
        reset_n = 1'b0;
        #1;
        chk("abort_clk_samp", int'(clk_samp), 1);
        chk("abort_sclk", int'(sclk), 1);
        chk("abort_no_valid", int'(sample_valid), 0);
        repeat (3) @(posedge basys_clock);
        #1;
        chk("abort_sample_zero", int'(sample), 0);
        chk("abort_level_zero", int'(audio_level), 0);
        @(negedge basys_clock);
        reset_n = 1'b1;

        n = 0;
        while (exp_s.size() > 0 && n < 2000) begin
            @(posedge basys_clock); n++;
        end
        chk("post_reset_timeout", exp_s.size(), 0);
        repeat (20) @(posedge basys_clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
